// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared types for the ID/EX pipeline register.
// Holds the control-word layout (10 bits), data width (32), register-index
// width (5), the stage state encoding and the bubble helper.
package id_ex_stage_pkg;

  localparam int unsigned CTRL_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  // Control word, MSB first: {aluOp[2:0], amemToReg, regWrite, amemToWrite,
  // branch, ALUSrc, amemToRead, regDist}.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_to_write;
    logic       branch;
    logic       alu_src;
    logic       mem_to_read;
    logic       reg_dist;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // One decode-to-execute bundle.
  typedef struct packed {
    ctrl_t             ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
  } bundle_t;

  // Strip every side-effecting bit so an idle stage looks like a bubble.
  function automatic ctrl_t bubble_ctrl(input ctrl_t c);
    ctrl_t r;
    r              = c;
    r.reg_write    = 1'b0;
    r.mem_to_write = 1'b0;
    r.mem_to_read  = 1'b0;
    r.branch       = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/id_ex_entry.sv
// id_ex_entry: one bundle register with load enable and clear.
// Ports: clk, rst (sync, active-high), clear (sync zero), load, d, q.
module id_ex_entry
  import id_ex_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clear,
  input  logic    load,
  input  bundle_t d,
  output bundle_t q
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with valid/ready handshake and flush.
// Ports: clk, rst (sync, active-high); decode side in_valid/in_ready and the
// bundle inputs ctrl_in, rd1_in, rd2_in, imm_in, pc4_in, rt_in, rd_in;
// flush; execute side out_valid/out_ready and the matching *_out bundle.
// Build option: define ID_EX_SKID_EN for a two-entry skid buffer with a
// registered in_ready; otherwise a single register with combinational in_ready.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [DATA_W-1:0] pc4_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [DATA_W-1:0] pc4_out,
  output logic [REG_W-1:0]  rt_out,
  output logic [REG_W-1:0]  rd_out
);

  bundle_t bundle_in;
  bundle_t main_d;
  bundle_t main_q;
  logic    load_main;
  logic    in_xfer;
  logic    out_xfer;
  logic    out_valid_q;

  assign bundle_in = {ctrl_in, rd1_in, rd2_in, imm_in, pc4_in, rt_in, rd_in};

`ifdef ID_EX_SKID_EN
  state_e  state;
  logic    in_ready_q;
  logic    load_skid;
  bundle_t skid_q;

  assign in_ready = in_ready_q;
  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  // Entry load enables; the skid entry drains into the output register.
  always_comb begin
    load_main = 1'b0;
    load_skid = 1'b0;
    main_d    = bundle_in;
    if (!flush) begin
      case (state)
        ST_EMPTY: load_main = in_xfer;
        ST_FULL: begin
          if (in_xfer) begin
            load_main = out_xfer;
            load_skid = !out_xfer;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            load_main = 1'b1;
            main_d    = skid_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Occupancy FSM; flush outranks everything except reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state       <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            state       <= ST_FULL;
            out_valid_q <= 1'b1;
          end
        end
        ST_FULL: begin
          if (in_xfer && !out_xfer) begin
            state      <= ST_SKID;
            in_ready_q <= 1'b0;
          end else if (!in_xfer && out_xfer) begin
            state       <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            state      <= ST_FULL;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  id_ex_entry u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (load_skid),
    .d     (bundle_in),
    .q     (skid_q)
  );
`else
  assign in_ready  = !out_valid_q || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;
  assign load_main = in_xfer && !flush;
  assign main_d    = bundle_in;

  // A new bundle replaces the departing one in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid_q <= 1'b0;
    end else if (in_xfer) begin
      out_valid_q <= 1'b1;
    end else if (out_xfer) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  // Output register keeps its data across a flush; only reset zeroes it.
  id_ex_entry u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .load  (load_main),
    .d     (main_d),
    .q     (main_q)
  );

  assign out_valid = out_valid_q;
  assign ctrl_out  = out_valid_q ? main_q.ctrl : bubble_ctrl(main_q.ctrl);
  assign rd1_out   = main_q.rd1;
  assign rd2_out   = main_q.rd2;
  assign imm_out   = main_q.imm;
  assign pc4_out   = main_q.pc4;
  assign rt_out    = main_q.rt;
  assign rd_out    = main_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage (either build option).
module tb_id_ex_stage;

`ifdef ID_EX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int CAP = SKID ? 2 : 1;

  typedef logic [147:0] bun_t;  // {ctrl, rd1, rd2, imm, pc4, rt, rd}

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [9:0]  ctrl_in, ctrl_out;
  logic [31:0] rd1_in, rd2_in, imm_in, pc4_in;
  logic [31:0] rd1_out, rd2_out, imm_out, pc4_out;
  logic [4:0]  rt_in, rd_in, rt_out, rd_out;
  bun_t        dut_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .pc4_in(pc4_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out),
    .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out),
    .pc4_out(pc4_out), .rt_out(rt_out), .rd_out(rd_out)
  );

  assign dut_b = {ctrl_out, rd1_out, rd2_out, imm_out, pc4_out, rt_out, rd_out};

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bun_t mk(input logic [9:0] c, input logic [31:0] d);
    return {c, d, ~d, d + 32'd1, {d[29:0], 2'b00}, d[4:0], ~d[4:0]};
  endfunction

  task automatic drive(input logic r, input logic fl, input logic iv,
                       input logic ordy, input bun_t b);
    rst = r; flush = fl; in_valid = iv; out_ready = ordy;
    {ctrl_in, rd1_in, rd2_in, imm_in, pc4_in, rt_in, rd_in} = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO of held bundles, head is what the stage shows.
  bun_t mq[$];
  bun_t shown;

  function automatic logic model_ready(input logic ordy);
    return (mq.size() < CAP) || (!SKID && ordy);
  endfunction

  function automatic logic [9:0] model_ctrl();
    logic [9:0] c;
    c = shown[147:138];
    // Idle stage keeps only aluOp, memToReg, ALUSrc, regDist.
    return (mq.size() > 0) ? c : (c & 10'h3C5);
  endfunction

  task automatic model_edge(input logic r, input logic fl, input logic iv,
                            input logic ordy, input bun_t b);
    logic ir, ov;
    ir = model_ready(ordy);
    ov = mq.size() > 0;
    if (r) begin
      mq.delete();
      shown = '0;
    end else if (fl) begin
      mq.delete();
    end else begin
      if (ov && ordy) void'(mq.pop_front());
      if (iv && ir) mq.push_back(b);
    end
    if (mq.size() > 0) shown = mq[0];
  endtask

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [9:0]  ctrl;
    logic [31:0] rd1;
    logic        exp_ov;
    logic [9:0]  exp_ctrl;
    logic [31:0] exp_rd1;
    logic        exp_ir;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bun_t        eb, nb, rb;
    logic [159:0] raw;
    logic        r, fl, iv, ordy;

    tbl[0] = '{1'b1, 1'b1, 10'h029, 32'h11, 1'b1, 10'h029, 32'h11, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 10'h000, 32'h00, 1'b0, 10'h001, 32'h11, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 10'h3C5, 32'hA,  1'b1, 10'h3C5, 32'hA,  1'b1};
    tbl[3] = '{1'b1, 1'b1, 10'h1FF, 32'hB,  1'b1, 10'h1FF, 32'hB,  1'b1};
    tbl[4] = '{1'b1, 1'b1, 10'h2AA, 32'hC,  1'b1, 10'h2AA, 32'hC,  1'b1};
    tbl[5] = '{1'b0, 1'b1, 10'h000, 32'h00, 1'b0, 10'h280, 32'hC,  1'b1};

    // Reset state
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    tick();
    chk("rst_out_valid", 160'(out_valid), 160'(1'b0));
    chk("rst_bundle", 160'(dut_b), 160'(0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    chk("rst_in_ready", 160'(in_ready), 160'(1'b1));

    // Single bundle, then back-to-back A, B, C
    foreach (tbl[i]) begin
      drive(1'b0, 1'b0, tbl[i].iv, tbl[i].ordy, mk(tbl[i].ctrl, tbl[i].rd1));
      tick();
      eb = mk(tbl[i].exp_ctrl, tbl[i].exp_rd1);
      chk($sformatf("tbl%0d_out_valid", i), 160'(out_valid), 160'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_ctrl", i), 160'(ctrl_out), 160'(tbl[i].exp_ctrl));
      chk($sformatf("tbl%0d_data", i), 160'(dut_b[137:0]), 160'(eb[137:0]));
      chk($sformatf("tbl%0d_in_ready", i), 160'(in_ready), 160'(tbl[i].exp_ir));
    end

    // Backpressure: D held for 3 cycles, E behind it
    drive(1'b0, 1'b0, 1'b1, 1'b1, mk(10'h155, 32'hD));
    tick();
    chk("bp_load_d", 160'(out_valid), 160'(1'b1));
    drive(1'b0, 1'b0, 1'b1, 1'b0, mk(10'h0E7, 32'hE));
    #1;
    chk("bp_in_ready_first", 160'(in_ready), 160'(SKID));
    tick();
    chk("bp_hold0", 160'(dut_b), 160'(mk(10'h155, 32'hD)));
    nb = SKID ? mk(10'h2F0, 32'hF) : mk(10'h0E7, 32'hE);
    for (int k = 1; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, nb);
      #1;
      chk($sformatf("bp_in_ready%0d", k), 160'(in_ready), 160'(1'b0));
      tick();
      chk($sformatf("bp_valid%0d", k), 160'(out_valid), 160'(1'b1));
      chk($sformatf("bp_hold%0d", k), 160'(dut_b), 160'(mk(10'h155, 32'hD)));
    end
    drive(1'b0, 1'b0, !SKID, 1'b1, mk(10'h0E7, 32'hE));
    tick();
    chk("bp_release_valid", 160'(out_valid), 160'(1'b1));
    chk("bp_release_e", 160'(dut_b), 160'(mk(10'h0E7, 32'hE)));
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    tick();
    chk("bp_drain_valid", 160'(out_valid), 160'(1'b0));
    chk("bp_drain_ctrl", 160'(ctrl_out), 160'(10'h0C5));
    tick();
    chk("bp_no_extra", 160'(out_valid), 160'(1'b0));

    // Flush with a simultaneous input transfer
    drive(1'b0, 1'b0, 1'b1, 1'b1, mk(10'h3FF, 32'h6));
    tick();
    chk("fl_load", 160'(out_valid), 160'(1'b1));
    drive(1'b0, 1'b1, 1'b1, 1'b1, mk(10'h1E0, 32'h7));
    tick();
    chk("fl_valid", 160'(out_valid), 160'(1'b0));
    chk("fl_ctrl_bubble", 160'(ctrl_out), 160'(10'h3C5));
    chk("fl_rd1_kept", 160'(rd1_out), 160'(32'h6));
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("fl_gone%0d", k), 160'(out_valid), 160'(1'b0));
      chk($sformatf("fl_rd1_%0d", k), 160'(rd1_out), 160'(32'h6));
    end

    // Reset while backed up
    drive(1'b0, 1'b0, 1'b1, 1'b1, mk(10'h0AA, 32'h8));
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, mk(10'h155, 32'h9));
    tick();
    chk("rs_held", 160'(dut_b), 160'(mk(10'h0AA, 32'h8)));
    chk("rs_in_ready_busy", 160'(in_ready), 160'(1'b0));
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    chk("rs_valid", 160'(out_valid), 160'(1'b0));
    chk("rs_zero", 160'(dut_b), 160'(0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    chk("rs_in_ready_after", 160'(in_ready), 160'(1'b1));
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    tick();
    chk("rs_no_ghost", 160'(out_valid), 160'(1'b0));
    chk("rs_zero_after", 160'(dut_b), 160'(0));

    // Random traffic against the queue model
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    model_edge(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    for (int c = 0; c < 500; c++) begin
      r    = ($urandom_range(0, 99) == 0);
      fl   = ($urandom_range(0, 24) == 0);
      iv   = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 55);
      raw  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rb   = raw[147:0];
      drive(r, fl, iv, ordy, rb);
      #1;
      chk($sformatf("rnd%0d_in_ready", c), 160'(in_ready), 160'(model_ready(ordy)));
      model_edge(r, fl, iv, ordy, rb);
      tick();
      chk($sformatf("rnd%0d_out_valid", c), 160'(out_valid), 160'(mq.size() > 0));
      chk($sformatf("rnd%0d_ctrl", c), 160'(ctrl_out), 160'(model_ctrl()));
      chk($sformatf("rnd%0d_data", c), 160'(dut_b[137:0]), 160'(shown[137:0]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
